// File: rtl/if_stage_ctrl_if.sv
// Bundle for the fetch-stage controller.
// The hazard/branch side drives the controls (pcwrite, ifid_write, flush,
// select, branch_target) and the instruction memory returns instr_i.
// The fetch stage drives the PC, the IF/ID register fields, the FSM state and
// the stall/flush event counters.
//   master : hazard unit / instruction memory side (drives controls, reads outputs)
//   slave  : if_stage_ctrl (reads controls, drives outputs)
interface if_stage_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              pcwrite;
    logic              ifid_write;
    logic              flush;          // active-low
    logic              select;
    logic [31:0]       branch_target;
    logic [31:0]       instr_i;
    logic [31:0]       pc_o;
    logic [31:0]       ifid_pc4_o;
    logic [31:0]       ifid_instr_o;
    logic              ifid_valid_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output pcwrite, ifid_write, flush, select, branch_target, instr_i,
        input  pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, state_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  pcwrite, ifid_write, flush, select, branch_target, instr_i,
        output pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, state_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: PC register, IF/ID pipeline register,
// a three-state status FSM and saturating stall/flush event counters.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : if_stage_ctrl_if.slave (controls in; PC, IF/ID, state, counters out)
// Every output comes straight from a register.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        BUBBLE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc4;
    logic [31:0] ifid_pc4_reg, ifid_pc4_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        ifid_valid_reg, ifid_valid_next;

    // Wraps naturally at 2^32.
    assign pc4 = pc_reg + 32'd4;

    // PC: a taken branch beats the stall hold.
    always_comb begin
        pc_next = pc_reg;
        if (bus.select) begin
            pc_next = bus.branch_target;
        end else if (bus.pcwrite) begin
            pc_next = pc4;
        end
    end

    // IF/ID: a flush bubble beats the hold requested by ifid_write=0.
    always_comb begin
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        if (!bus.flush) begin
            ifid_pc4_next   = 32'h0;
            ifid_instr_next = 32'h0;
            ifid_valid_next = 1'b0;
        end else if (bus.ifid_write) begin
            ifid_pc4_next   = pc4;
            ifid_instr_next = bus.instr_i;
            ifid_valid_next = 1'b1;
        end
    end

    // State only reflects this cycle's controls; any combination that is
    // neither a redirect/flush nor a PC hold reports RUN.
    always_comb begin
        state_next = RUN;
        if (!bus.flush || bus.select) begin
            state_next = BUBBLE;
        end else if (!bus.pcwrite) begin
            state_next = STALL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            ifid_pc4_reg   <= 32'h0;
            ifid_instr_reg <= 32'h0;
            ifid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
        end
    end

    // Event counters: index 0 counts stalled cycles (PC held without a
    // redirect), index 1 counts flush events. Both may step in one cycle.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = !bus.select && !bus.pcwrite;
    assign cnt_inc[1] = !bus.flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign bus.pc_o         = pc_reg;
    assign bus.ifid_pc4_o   = ifid_pc4_reg;
    assign bus.ifid_instr_o = ifid_instr_reg;
    assign bus.ifid_valid_o = ifid_valid_reg;
    assign bus.state_o      = state_reg;
    assign bus.stall_cnt_o  = cnt_val[0];
    assign bus.flush_cnt_o  = cnt_val[1];
endmodule
